// File: rtl/alu_add_accumulator.sv
// Sequencing stage around a 16-bit adder: sums bursts of N_OPS operands and hands out sum plus flags.
// Define ALU_ACC_SAT_EN to clamp the accumulator to the signed range on overflow instead of wrapping.
module alu_add_accumulator #(
    parameter int unsigned N_OPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        flush,
    output logic [15:0] add_x,
    output logic [15:0] add_y,
    input  logic [15:0] add_z,
    input  logic        add_carry,
    input  logic        add_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic [4:0]  out_flags
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_OPS - 1);

    state_t      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stkCarry_q, stkCarry_d;
    logic        stkOvf_q, stkOvf_d;
    logic [15:0] outSum_q, outSum_d;
    logic [4:0]  outFlags_q, outFlags_d;

    logic        accept;
    logic        finish;
    logic [15:0] beatSum;
    logic [15:0] finalAcc;
    logic        finalCarry;
    logic        finalOvf;

    assign add_x     = acc_q;
    assign add_y     = in_data;
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = outSum_q;
    assign out_flags = outFlags_q;

    // Value the accumulator takes on an accepted beat; the clamp follows the sign of the running total.
    always_comb begin
        beatSum = add_z;
`ifdef ALU_ACC_SAT_EN
        if (add_overflow) begin
            beatSum = add_x[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        stkCarry_d = stkCarry_q;
        stkOvf_d   = stkOvf_q;
        outSum_d   = outSum_q;
        outFlags_d = outFlags_q;

        accept     = (state_q == ACC) && in_valid;
        finalAcc   = accept ? beatSum : acc_q;
        finalCarry = stkCarry_q | (accept & add_carry);
        finalOvf   = stkOvf_q | (accept & add_overflow);
        finish     = (accept && (cnt_q == LAST_CNT)) ||
                     ((state_q == ACC) && flush && (accept || (cnt_q != 8'd0)));

        case (state_q)
            ACC: begin
                if (finish) begin
                    state_d    = HOLD;
                    outSum_d   = finalAcc;
                    outFlags_d = {finalAcc[15], ~|finalAcc, finalCarry, ~^finalAcc, finalOvf};
                    acc_d      = 16'h0000;
                    cnt_d      = 8'd0;
                    stkCarry_d = 1'b0;
                    stkOvf_d   = 1'b0;
                end else if (accept) begin
                    acc_d      = beatSum;
                    cnt_d      = cnt_q + 8'd1;
                    stkCarry_d = finalCarry;
                    stkOvf_d   = finalOvf;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= 16'h0000;
            cnt_q      <= 8'd0;
            stkCarry_q <= 1'b0;
            stkOvf_q   <= 1'b0;
            outSum_q   <= 16'h0000;
            outFlags_q <= 5'b00000;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            stkCarry_q <= stkCarry_d;
            stkOvf_q   <= stkOvf_d;
            outSum_q   <= outSum_d;
            outFlags_q <= outFlags_d;
        end
    end

endmodule
